serial_regfile: RTL

SERIAL_REGFILE -- requirements
Module: serial_regfile

---
 rtl/serial_regfile.sv | 123 ++++++++++++
 1 files changed

// File: rtl/serial_regfile.sv
// serial_regfile: bit-serial access to an NREGS x XLEN register file.
//
// A frame {op[1:0], addr[AW-1:0], data[XLEN-1:0]} is shifted in MSB first
// on sdi, starting in the cycle start is seen in IDLE. One EXEC cycle then
// performs the access; READ and SWAP stream the returned word out on sdo,
// MSB first, over XLEN TX cycles.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  frame start strobe, only looked at in IDLE
//   sdi    serial frame input
//   sdo    serial read data, 0 outside TX
//   busy   high whenever the FSM is not in IDLE
//   done   one-cycle pulse in the first IDLE cycle after a frame
//   err    one-cycle pulse in EXEC when addr >= NREGS
module serial_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic sdi,
    output logic sdo,
    output logic busy,
    output logic done,
    output logic err
);
    localparam int AW = $clog2(NREGS);
    localparam int F  = 2 + AW + XLEN;
    localparam int CW = $clog2(F);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    typedef enum logic [1:0] {IDLE, RX, EXEC, TX} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [F-1:0]    frame_sr;
    logic [XLEN-1:0] out_sr;
    logic [XLEN-1:0] rf [NREGS];

    logic [1:0]      op;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] wdata;
    logic            in_range;
    logic            is_tx;
    logic            is_wr;
    logic            rx_last;
    logic            tx_last;
    logic [XLEN-1:0] rd_word;

    // Frame fields are only meaningful in EXEC, once all F bits are in.
    assign op       = frame_sr[F-1 -: 2];
    assign addr     = frame_sr[XLEN +: AW];
    assign wdata    = frame_sr[XLEN-1:0];
    // Widened compare so non-power-of-two NREGS can reject high addresses.
    assign in_range = ({1'b0, addr} < NREGS_W);
    // op[0] set: READ/SWAP return data; op[1] set: WRITE/SWAP store data.
    assign is_tx    = op[0];
    assign is_wr    = op[1];
    assign rx_last  = (cnt == CW'(F-1));
    assign tx_last  = (cnt == CW'(XLEN-1));
    assign rd_word  = in_range ? rf[addr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RX;
            RX:      if (rx_last) state_nxt = EXEC;
            EXEC:    state_nxt = is_tx ? TX : IDLE;
            TX:      if (tx_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            frame_sr <= '0;
            out_sr   <= '0;
            done     <= 1'b0;
        end else begin
            done <= ((state == EXEC) && !is_tx) || ((state == TX) && tx_last);
            case (state)
                IDLE: begin
                    cnt <= start ? CW'(1) : '0;
                    if (start) frame_sr <= {frame_sr[F-2:0], sdi};
                end
                RX: begin
                    frame_sr <= {frame_sr[F-2:0], sdi};
                    cnt      <= cnt + CW'(1);
                end
                EXEC: begin
                    cnt <= '0;
                    if (is_tx) out_sr <= rd_word;
                end
                TX: begin
                    out_sr <= out_sr << 1;
                    cnt    <= cnt + CW'(1);
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Storage is not reset; the write is gated by rst_n so a reset cycle
    // never commits. rd_word is taken from the pre-write value (SWAP).
    always_ff @(posedge clk) begin
        if (rst_n && (state == EXEC) && is_wr && in_range)
            rf[addr] <= wdata;
    end

    assign busy = (state != IDLE);
    assign err  = (state == EXEC) && !in_range;
    assign sdo  = (state == TX) && out_sr[XLEN-1];

endmodule
